axis_rx_byte_serializer: RTL
============================

AXIS_RX_BYTE_SERIALIZER -- requirements
Module: axis_rx_byte_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 64, AXIS data width in bits; only 64 supported (8 byte lanes).
REQ-002 SHALL have parameter BCNT_WIDTH, 32, width of the byte-count output.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 rx_mac_aclk  in  1  RX clock; all logic on rising edge.
REQ-005 reset_  in  1  asynchronous active-low reset.
REQ-006 rx_axis_mac_tdata  in  DATA_WIDTH  AXIS beat; lane k = bits [8k+7:8k].
REQ-007 rx_axis_mac_tkeep  in  DATA_WIDTH/8  lane-valid mask.
REQ-008 rx_axis_mac_tvalid  in  1  beat valid.
REQ-009 rx_axis_mac_tlast  in  1  last beat of packet.
REQ-010 rx_axis_mac_tuser  in  1  packet error; sampled on the tlast beat only.
REQ-011 rx_axis_mac_tready  out  1  beat accept.
REQ-012 byte_data  out  8  serialized byte.
REQ-013 byte_vld  out  1  byte_data valid.
REQ-014 byte_rdy  in  1  downstream accepts byte when byte_vld and byte_rdy are both high.
REQ-015 byte_sop / byte_eop  out  1 each  first / last byte of packet, qualified by byte_vld.
REQ-016 axis_rd_done_st  out  1  one-cycle packet-complete pulse.
REQ-017 rx_axis_mac_tbcnt  out  BCNT_WIDTH  byte count of last completed packet.
REQ-018 pkt_cnt  out  32  completed packets; err_pkt_cnt  out  32  completed packets with tuser=1.

Function
REQ-019 FSM states SHALL be IDLE, SHIFT, NEXT, DONE.
REQ-020 rx_axis_mac_tready SHALL be 1 exactly in IDLE and NEXT; a beat transfers when tvalid and tready are both high.
REQ-021 On transfer, tdata, tkeep, tlast and tuser SHALL be captured into holding registers; next state SHIFT if tkeep != 0, else DONE if tlast, else NEXT.
REQ-022 In SHIFT, byte_vld SHALL be high, and byte_data SHALL be the lowest-numbered lane still marked pending in the held keep mask.
REQ-023 On each byte handshake, that lane's pending bit SHALL clear and the packet byte counter SHALL increment by 1.
REQ-024 When byte_vld is high and byte_rdy is low, byte_data, byte_sop and byte_eop SHALL hold stable.
REQ-025 Non-contiguous tkeep SHALL be supported: lanes with keep=0 are skipped, and remaining lanes are emitted in ascending order.
REQ-026 byte_sop SHALL be high on the first emitted byte after IDLE.
REQ-027 byte_eop SHALL be high on the last pending lane of a tlast beat.
REQ-028 After the last pending lane is taken, next state SHALL be DONE if the held tlast is 1, else NEXT.
REQ-029 DONE SHALL last exactly one cycle, then go to IDLE, and in that cycle:
  - axis_rd_done_st = 1;
  - rx_axis_mac_tbcnt <= packet byte counter;
  - pkt_cnt increments;
  - err_pkt_cnt increments if the held tuser = 1;
  - the packet byte counter clears.
REQ-030 rx_axis_mac_tbcnt SHALL hold its value until the next DONE.
REQ-031 pkt_cnt and err_pkt_cnt SHALL wrap modulo 2^32.
REQ-032 The packet byte counter SHALL saturate at 2^BCNT_WIDTH-1.
REQ-033 A zero-byte packet (first beat tkeep=0, tlast=1) SHALL go IDLE->DONE with tbcnt=0 and pkt_cnt incremented; no byte_vld is asserted.
REQ-034 tuser on non-tlast beats SHALL be ignored.
REQ-035 Latency: first byte_vld SHALL assert on the cycle after beat transfer; axis_rd_done_st SHALL assert on the cycle after the eop handshake.
REQ-036 Throughput SHALL be 1 byte/cycle while byte_rdy=1; each beat costs 1 extra cycle in NEXT.

Reset
REQ-037 While reset_=0, state SHALL be IDLE and outputs SHALL be:
  - rx_axis_mac_tready=0, byte_vld=0, byte_sop=0, byte_eop=0, axis_rd_done_st=0;
  - byte_data=0, rx_axis_mac_tbcnt=0, pkt_cnt=0, err_pkt_cnt=0;
  - all holding registers and counters cleared.
REQ-038 Reset asserted mid-packet SHALL discard the partial packet with no DONE pulse; after release, the first accepted beat starts a new packet with byte_sop.
REQ-039 After reset release, tready SHALL rise on the first rising edge.

Verification
REQ-040 Single beat, tdata=0x0807060504030201, tkeep=0xFF, tlast=1, byte_rdy=1 -> bytes 01..08 on 8 consecutive cycles, sop on 01, eop on 08; then done pulse, tbcnt=8, pkt_cnt=1.
REQ-041 Two beats, keep 0xFF then 0x07 (tlast) -> 11 bytes, eop on the 11th byte, tbcnt=11, tready low during SHIFT.
REQ-042 Beat tkeep=0xA5, tlast=1 -> lanes 0,2,5,7 emitted in order, tbcnt=4.
REQ-043 Same as REQ-040 with byte_rdy toggling 1,0,1,0 -> each byte held stable while byte_rdy=0, no loss or duplication, tbcnt=8.
REQ-044 Zero-byte packet, then 64-byte packet with tuser=1 on tlast -> tbcnt 0 then 64, pkt_cnt=2, err_pkt_cnt=1.
REQ-045 reset_ pulsed low after 3 bytes of an 8-byte packet -> outputs zero immediately with no done pulse; the next 8-byte packet gives pkt_cnt=1, tbcnt=8.

Source files
------------

// File: rtl/axis_rx_byte_serializer.sv
// Serializes 64-bit AXI-Stream RX beats into a byte stream, lowest kept lane first.
// The FSM also maintains the per-packet byte count and the total/errored packet counters.
module axis_rx_byte_serializer #(
  parameter int DATA_WIDTH = 64,
  parameter int BCNT_WIDTH = 32
) (
  input  logic                    rx_mac_aclk,
  input  logic                    reset_,
  input  logic [DATA_WIDTH-1:0]   rx_axis_mac_tdata,
  input  logic [DATA_WIDTH/8-1:0] rx_axis_mac_tkeep,
  input  logic                    rx_axis_mac_tvalid,
  input  logic                    rx_axis_mac_tlast,
  input  logic                    rx_axis_mac_tuser,
  output logic                    rx_axis_mac_tready,
  output logic [7:0]              byte_data,
  output logic                    byte_vld,
  input  logic                    byte_rdy,
  output logic                    byte_sop,
  output logic                    byte_eop,
  output logic                    axis_rd_done_st,
  output logic [BCNT_WIDTH-1:0]   rx_axis_mac_tbcnt,
  output logic [31:0]             pkt_cnt,
  output logic [31:0]             err_pkt_cnt
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int LW    = $clog2(LANES);

  // state | meaning
  // IDLE  | waiting for the first beat of a packet
  // SHIFT | emitting pending lanes of the held beat
  // NEXT  | waiting for the following beat of the same packet
  // DONE  | one-cycle packet completion, counters update
  typedef enum logic [1:0] {IDLE, SHIFT, NEXT, DONE} state_t;

  state_t                state, state_nxt;
  logic                  run;
  logic [DATA_WIDTH-1:0] data_q;
  logic [LANES-1:0]      keep_q;
  logic                  last_q;
  logic                  user_q;
  logic                  sop_q;
  logic [BCNT_WIDTH-1:0] byte_cnt;
  logic [LW-1:0]         lane;
  logic [LANES-1:0]      keep_rem;
  logic                  beat_xfer;
  logic                  byte_xfer;

  always_comb begin
    lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (keep_q[i]) lane = LW'(i);
    end
  end

  assign keep_rem  = keep_q & ~(LANES'(1) << lane);
  assign byte_data = data_q[{lane, 3'b000} +: 8];
  assign byte_sop  = byte_vld & sop_q;
  assign byte_eop  = byte_vld & last_q & (keep_rem == '0);
  assign beat_xfer = rx_axis_mac_tvalid & rx_axis_mac_tready;
  assign byte_xfer = byte_vld & byte_rdy;

  always_ff @(posedge rx_mac_aclk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    rx_axis_mac_tready = 1'b0;
    byte_vld           = 1'b0;
    axis_rd_done_st    = 1'b0;
    case (state)
      IDLE, NEXT: begin
        rx_axis_mac_tready = run;
        if (rx_axis_mac_tvalid && run) begin
          if (|rx_axis_mac_tkeep)     state_nxt = SHIFT;
          else if (rx_axis_mac_tlast) state_nxt = DONE;
          else                        state_nxt = NEXT;
        end
      end
      SHIFT: begin
        byte_vld = 1'b1;
        if (byte_rdy && keep_rem == '0) state_nxt = last_q ? DONE : NEXT;
      end
      DONE: begin
        axis_rd_done_st = 1'b1;
        state_nxt       = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // run keeps tready low until the first clock edge after reset release
  always_ff @(posedge rx_mac_aclk or negedge reset_) begin
    if (!reset_) begin
      run               <= 1'b0;
      data_q            <= '0;
      keep_q            <= '0;
      last_q            <= 1'b0;
      user_q            <= 1'b0;
      sop_q             <= 1'b0;
      byte_cnt          <= '0;
      rx_axis_mac_tbcnt <= '0;
      pkt_cnt           <= '0;
      err_pkt_cnt       <= '0;
    end else begin
      run <= 1'b1;
      if (beat_xfer) begin
        data_q <= rx_axis_mac_tdata;
        keep_q <= rx_axis_mac_tkeep;
        last_q <= rx_axis_mac_tlast;
        user_q <= rx_axis_mac_tuser & rx_axis_mac_tlast;
        if (state == IDLE) sop_q <= 1'b1;
      end
      if (byte_xfer) begin
        keep_q <= keep_rem;
        sop_q  <= 1'b0;
        if (byte_cnt != '1) byte_cnt <= byte_cnt + BCNT_WIDTH'(1);
      end
      if (state == DONE) begin
        rx_axis_mac_tbcnt <= byte_cnt;
        pkt_cnt           <= pkt_cnt + 32'd1;
        if (user_q) err_pkt_cnt <= err_pkt_cnt + 32'd1;
        byte_cnt <= '0;
        sop_q    <= 1'b0;
      end
    end
  end

endmodule
